// File: rtl/hydra_pkg.sv
// Shared types and constants for the Hydra TX scheduler: FSM state encoding,
// routing bit position and statistics counter width.
package hydra_pkg;

  localparam int unsigned DOWNSTREAM_BIT = 62;
  localparam int unsigned COUNT_W        = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StDrop,
    StWaitIdle,
    StLoad,
    StSettle
  } sched_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hydra_tx_scheduler.sv
// Event FIFO reader for the Hydra TX router: pops one event, waits for its target
// UARTs to go idle (or times out), pulses ld_tx_data and holds the data through settle.
module hydra_tx_scheduler
  import hydra_pkg::*;
#(
  parameter int unsigned Width         = 64,
  parameter int unsigned DownstreamBit = DOWNSTREAM_BIT,
  parameter int unsigned SettleCycles  = 4,
  parameter int unsigned TimeoutCycles = 63
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               sched_enable_i,
  input  logic               fifo_empty_i,
  input  logic [Width-1:0]   fifo_rd_data_i,
  output logic               fifo_rd_o,
  output logic [Width-1:0]   fifo_data_o,
  output logic               ld_tx_data_o,
  input  logic [3:0]         enable_piso_upstream_i,
  input  logic [3:0]         enable_piso_downstream_i,
  input  logic [3:0]         tx_busy_i,
  input  logic               clear_flags_i,
  output logic               tx_timeout_flag_o,
  output logic               sched_busy_o,
  output logic [COUNT_W-1:0] drop_count_o,
  output logic [COUNT_W-1:0] sent_count_o
);

  localparam int unsigned WaitW   = $clog2(TimeoutCycles + 1);
  localparam int unsigned SettleW = $clog2(SettleCycles + 1);
  localparam logic [WaitW-1:0]   WaitLimit  = WaitW'(TimeoutCycles);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleCycles - 1);

  sched_state_e        state_q, state_d;
  logic [WaitW-1:0]    wait_q, wait_d, wait_inc;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [3:0]          mask_q, mask_d, cap_mask;
  logic [Width-1:0]    data_q, data_d;
  logic                flag_q, flag_d;
  logic                fifo_rd_q, ld_q, busy_q;
  logic                force_load;

  assign cap_mask = fifo_rd_data_i[DownstreamBit] ? enable_piso_downstream_i
                                                  : enable_piso_upstream_i;
  assign wait_inc = wait_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    settle_d   = settle_q;
    mask_d     = mask_q;
    data_d     = data_q;
    force_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sched_enable_i && !fifo_empty_i) state_d = StFetch;
      end
      StFetch: state_d = StCapture;
      StCapture: begin
        data_d  = fifo_rd_data_i;
        mask_d  = cap_mask;
        wait_d  = '0;
        state_d = (cap_mask == 4'b0) ? StDrop : StWaitIdle;
      end
      StDrop: state_d = StIdle;
      StWaitIdle: begin
        // An idle target wins over a coincident timeout: that is a normal load.
        if ((tx_busy_i & mask_q) == 4'b0) begin
          state_d = StLoad;
        end else if (wait_inc == WaitLimit) begin
          state_d    = StLoad;
          force_load = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      StLoad: begin
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == SettleLast) state_d = StIdle;
        else settle_d = settle_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    flag_d = flag_q | force_load;
    if (clear_flags_i) flag_d = 1'b0;
  end

  // Strobes are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      settle_q  <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      flag_q    <= 1'b0;
      fifo_rd_q <= 1'b0;
      ld_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      settle_q  <= settle_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      flag_q    <= flag_d;
      fifo_rd_q <= (state_d == StFetch);
      ld_q      <= (state_d == StLoad);
      busy_q    <= (state_d != StIdle);
    end
  end

  sat_counter #(
    .Width (COUNT_W)
  ) u_drop_count (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .clr_i   (clear_flags_i),
    .inc_i   (state_q == StDrop),
    .count_o (drop_count_o)
  );

  sat_counter #(
    .Width (COUNT_W)
  ) u_sent_count (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .clr_i   (clear_flags_i),
    .inc_i   (state_q == StLoad),
    .count_o (sent_count_o)
  );

  assign fifo_rd_o         = fifo_rd_q;
  assign ld_tx_data_o      = ld_q;
  assign sched_busy_o      = busy_q;
  assign fifo_data_o       = data_q;
  assign tx_timeout_flag_o = flag_q;

endmodule

// File: tb/tb_hydra_tx_scheduler.sv
// Bench for hydra_tx_scheduler: directed scenarios plus randomized traffic, all
// checked against an event-level timing model built from plain cycle arithmetic.
module tb_hydra_tx_scheduler;

  localparam int MaxCyc = 1200;

  logic        clk, reset, sched_enable, fifo_empty, fifo_rd, ld_tx_data;
  logic        clear_flags, tx_timeout_flag, sched_busy;
  logic [63:0] fifo_rd_data, fifo_data;
  logic [3:0]  up, dn, tx_busy;
  logic [15:0] drop_count, sent_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] ev_q[$];
  logic [63:0] fifo_q[$];
  logic [3:0]  busy_at [MaxCyc];
  logic [3:0]  up_at   [MaxCyc];
  logic [3:0]  dn_at   [MaxCyc];
  logic        en_at   [MaxCyc];
  bit          exp_rd  [MaxCyc];
  bit          exp_ld  [MaxCyc];
  bit          exp_sb  [MaxCyc];
  bit          exp_hold[MaxCyc];
  logic [63:0] exp_data[MaxCyc];
  int          exp_sent, exp_drop, exp_left, scen_len;
  bit          exp_flag;

  hydra_tx_scheduler u_dut (
    .clk_i                    (clk),
    .reset_i                  (reset),
    .sched_enable_i           (sched_enable),
    .fifo_empty_i             (fifo_empty),
    .fifo_rd_data_i           (fifo_rd_data),
    .fifo_rd_o                (fifo_rd),
    .fifo_data_o              (fifo_data),
    .ld_tx_data_o             (ld_tx_data),
    .enable_piso_upstream_i   (up),
    .enable_piso_downstream_i (dn),
    .tx_busy_i                (tx_busy),
    .clear_flags_i            (clear_flags),
    .tx_timeout_flag_o        (tx_timeout_flag),
    .sched_busy_o             (sched_busy),
    .drop_count_o             (drop_count),
    .sent_count_o             (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " fifo_rd"}, 64'(fifo_rd), 64'd0);
    check({tag, " ld"}, 64'(ld_tx_data), 64'd0);
    check({tag, " flag"}, 64'(tx_timeout_flag), 64'd0);
    check({tag, " busy"}, 64'(sched_busy), 64'd0);
    check({tag, " data"}, fifo_data, 64'd0);
    check({tag, " drop"}, 64'(drop_count), 64'd0);
    check({tag, " sent"}, 64'(sent_count), 64'd0);
  endtask

  // Event-level model: each event starts when the scheduler is idle and enabled,
  // pops 1 cycle later, captures its mask at +2, waits from +3, loads when idle
  // or after 63 busy cycles, then settles 4 cycles; a drop returns to idle at +4.
  function automatic void predict();
    int          s;
    int          ld_c;
    int          end_c;
    int          done;
    bit          forced;
    logic [3:0]  mask;
    for (int c = 0; c < MaxCyc; c++) begin
      exp_rd[c] = 0; exp_ld[c] = 0; exp_sb[c] = 0; exp_hold[c] = 0; exp_data[c] = '0;
    end
    exp_sent = 0; exp_drop = 0; exp_flag = 0;
    s = 0; done = 0;
    for (int e = 0; e < ev_q.size(); e++) begin
      while (s < scen_len && !en_at[s]) s++;
      if (s >= scen_len) break;
      exp_rd[s + 1] = 1;
      mask = ev_q[e][62] ? dn_at[s + 2] : up_at[s + 2];
      if (mask == 4'b0) begin
        exp_drop++;
        end_c = s + 4;
      end else begin
        ld_c = s + 66;
        forced = 1;
        for (int c = s + 3; c <= s + 65; c++) begin
          if ((busy_at[c] & mask) == 4'b0) begin
            ld_c = c + 1;
            forced = 0;
            break;
          end
        end
        exp_ld[ld_c] = 1;
        for (int k = 0; k < 5; k++) begin
          exp_hold[ld_c + k] = 1;
          exp_data[ld_c + k] = ev_q[e];
        end
        exp_sent++;
        exp_flag |= forced;
        end_c = ld_c + 5;
      end
      for (int k = s + 1; k < end_c; k++) exp_sb[k] = 1;
      s = end_c;
      done++;
    end
    exp_left = ev_q.size() - done;
  endfunction

  task automatic drive(input int c);
    tx_busy      = busy_at[c];
    up           = up_at[c];
    dn           = dn_at[c];
    sched_enable = en_at[c];
    fifo_empty   = (fifo_q.size() == 0);
  endtask

  task automatic tick(input int c);
    @(posedge clk);
    #1;
    if (fifo_rd === 1'b1 && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    drive(c);
  endtask

  task automatic set_const(input logic [3:0] b, input logic [3:0] u, input logic [3:0] d,
                           input logic e);
    for (int c = 0; c < MaxCyc; c++) begin
      busy_at[c] = b; up_at[c] = u; dn_at[c] = d; en_at[c] = e;
    end
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    sched_enable = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    tx_busy      = '0;
    up           = '0;
    dn           = '0;
    clear_flags  = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
  endtask

  task automatic run_scenario(input string name);
    fifo_q = ev_q;
    predict();
    drive(0);
    for (int c = 1; c < scen_len; c++) begin
      tick(c);
      check($sformatf("%s fifo_rd c%0d", name, c), 64'(fifo_rd), 64'(exp_rd[c]));
      check($sformatf("%s ld c%0d", name, c), 64'(ld_tx_data), 64'(exp_ld[c]));
      check($sformatf("%s busy c%0d", name, c), 64'(sched_busy), 64'(exp_sb[c]));
      if (exp_hold[c]) check($sformatf("%s data c%0d", name, c), fifo_data, exp_data[c]);
    end
    check({name, " sent_count"}, 64'(sent_count), 64'(exp_sent));
    check({name, " drop_count"}, 64'(drop_count), 64'(exp_drop));
    check({name, " timeout_flag"}, 64'(tx_timeout_flag), 64'(exp_flag));
    check({name, " fifo_left"}, 64'(fifo_q.size()), 64'(exp_left));
  endtask

  task automatic gen_random(input int n_ev);
    int          c;
    int          len;
    logic [3:0]  b, u, d;
    logic [63:0] w;
    c = 0;
    while (c < MaxCyc) begin
      len = ($urandom_range(0, 7) == 0) ? 70 : int'($urandom_range(1, 10));
      b = 4'($urandom);
      u = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom);
      d = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom);
      for (int k = 0; k < len; k++) begin
        if (c < MaxCyc) begin
          busy_at[c] = b; up_at[c] = u; dn_at[c] = d;
          en_at[c] = ($urandom_range(0, 3) != 0);
          c++;
        end
      end
    end
    ev_q = {};
    for (int i = 0; i < n_ev; i++) begin
      w = {$urandom, $urandom};
      w[62] = 1'($urandom_range(0, 1));
      ev_q.push_back(w);
    end
    scen_len = n_ev * 72 + 100;
  endtask

  initial begin
    apply_reset();
    set_const(4'b0, 4'b0011, 4'b0, 1'b1);
    ev_q = {64'h0000_0000_DEAD_BEEF};
    scen_len = 20;
    run_scenario("upstream");

    apply_reset();
    set_const(4'b0, 4'b0, 4'b1000, 1'b1);
    for (int c = 0; c < 10; c++) busy_at[c] = 4'b1000;
    ev_q = {64'h4000_0000_0000_0001};
    scen_len = 25;
    run_scenario("downstream");

    apply_reset();
    set_const(4'b0, 4'b0, 4'b0, 1'b1);
    ev_q = {64'h0000_0000_0000_1234};
    scen_len = 10;
    run_scenario("drop");

    apply_reset();
    set_const(4'b0001, 4'b0001, 4'b0, 1'b1);
    ev_q = {64'h0000_0000_0000_00A5};
    scen_len = 80;
    run_scenario("timeout");
    clear_flags = 1'b1;
    @(posedge clk);
    #1;
    clear_flags = 1'b0;
    check("clear flag", 64'(tx_timeout_flag), 64'd0);
    check("clear sent", 64'(sent_count), 64'd0);
    check("clear drop", 64'(drop_count), 64'd0);

    apply_reset();
    set_const(4'b0, 4'b1111, 4'b1111, 1'b1);
    for (int c = 10; c < MaxCyc; c++) en_at[c] = 1'b0;
    ev_q = {64'h0000_0000_0000_0011, 64'h4000_0000_0000_0022, 64'h0000_0000_0000_0033};
    scen_len = 40;
    run_scenario("burst");

    apply_reset();
    set_const(4'b0001, 4'b0001, 4'b0, 1'b1);
    fifo_q = {64'h0000_0000_0BAD_F00D};
    drive(0);
    for (int c = 1; c <= 5; c++) tick(c);
    check("mid wait busy", 64'(sched_busy), 64'd1);
    reset = 1'b1;
    #1;
    check_zero("async reset");
    @(posedge clk);
    #1;
    check_zero("held reset");
    reset = 1'b0;
    set_const(4'b0, 4'b0001, 4'b0, 1'b1);
    ev_q = {64'h0000_0000_CAFE_0001};
    scen_len = 20;
    run_scenario("after_reset");

    for (int r = 0; r < 3; r++) begin
      apply_reset();
      gen_random(10);
      run_scenario($sformatf("random%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hydra_tx_scheduler.md
Name: hydra_tx_scheduler

Overview:
- Reader side of the event FIFO feeding the Hydra TX router.
- Pops one event at a time and registers it onto fifo_data, then waits until every UART that will transmit the event is idle.
- Issues a one-cycle ld_tx_data and holds fifo_data stable long enough for the router to latch it.
- Paces traffic so no TX UART is overwritten while busy, and counts dropped and timed-out events.

Parameters:
- WIDTH, 64, packet width without start/stop bits.
- DOWNSTREAM_BIT, 62, packet bit selecting downstream (1) or upstream (0) routing.
- SETTLE_CYCLES, 4, cycles fifo_data is held after ld_tx_data before the next fetch (min 2).
- TIMEOUT_CYCLES, 63, maximum cycles spent in WAIT_IDLE before a forced load.

Ports:
- clk  input  1  master clock
- reset  input  1  asynchronous reset, active high
- sched_enable  input  1  high allows new fetches; an in-flight event always completes
- fifo_empty  input  1  event FIFO empty
- fifo_rd_data  input  WIDTH  FIFO read data, valid the cycle after fifo_rd
- fifo_rd  output  1  one-cycle FIFO pop strobe
- fifo_data  output  WIDTH  registered event presented to the TX router
- ld_tx_data  output  1  one-cycle load strobe to the TX router
- enable_piso_upstream  input  4  upstream TX enables
- enable_piso_downstream  input  4  downstream TX enables
- tx_busy  input  4  per-UART busy
- clear_flags  input  1  synchronous clear of the sticky flag and both counters
- tx_timeout_flag  output  1  sticky; set on any forced load
- sched_busy  output  1  high in any state other than IDLE
- drop_count  output  16  saturating count of events with an empty target mask
- sent_count  output  16  saturating count of loads issued

Behaviour:
- Reset values:
  - fifo_rd, ld_tx_data, tx_timeout_flag, sched_busy = 0.
  - fifo_data, drop_count, sent_count = 0.
  - State = IDLE; wait and settle counters = 0.
- State machine (all outputs registered, Moore):
  - IDLE: sched_enable and !fifo_empty -> FETCH; otherwise stay.
  - FETCH: fifo_rd=1 for exactly one cycle -> CAPTURE.
  - CAPTURE:
    - fifo_data <= fifo_rd_data.
    - Latch the target mask: enable_piso_downstream if fifo_rd_data[DOWNSTREAM_BIT], else enable_piso_upstream.
    - Mask == 0 -> DROP; otherwise -> WAIT_IDLE.
  - DROP: drop_count increments by one -> IDLE. No ld_tx_data is issued.
  - WAIT_IDLE:
    - (tx_busy & mask) == 0 -> LOAD.
    - Otherwise increment the wait counter.
    - When the wait counter reaches TIMEOUT_CYCLES -> LOAD and set tx_timeout_flag.
  - LOAD: ld_tx_data=1 for one cycle; sent_count increments by one -> SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles -> IDLE.
- Latency and throughput:
  - IDLE sees fifo_empty=0 at cycle 0 with targets idle: fifo_rd at cycle 1, ld_tx_data at cycle 4.
  - Back-to-back events: ld_tx_data spacing = 5 + SETTLE_CYCLES cycles (9 at defaults).
- Data stability:
  - fifo_data changes only in CAPTURE.
  - It is held from CAPTURE through the end of SETTLE, which guarantees stability for the router's two-cycle latch path.
- Target mask:
  - Latched once per event in CAPTURE.
  - Enable changes during WAIT_IDLE do not alter the idle check.
- sched_enable deassertion:
  - Blocks only the IDLE -> FETCH transition.
  - An event that has been popped always completes, via LOAD or DROP.
- Counters:
  - Saturate at 16'hFFFF and do not wrap.
  - clear_flags zeroes both counters and tx_timeout_flag.
  - If clear_flags coincides with an increment or a flag set, the clear wins.
- tx_busy deasserting in the same cycle the wait counter hits TIMEOUT_CYCLES: the result is a normal LOAD with no flag set.
- fifo_empty rising during FETCH: no effect; the FIFO guarantees that data popped while non-empty is valid.
- Reset mid-operation:
  - Returns immediately to IDLE with every output at its reset value.
  - A popped-but-unloaded event is lost; this is the accepted behaviour.

Decomposition:
- Shared package hydra_pkg holds:
  - the state enum (IDLE, FETCH, CAPTURE, DROP, WAIT_IDLE, LOAD, SETTLE);
  - the DOWNSTREAM_BIT constant;
  - the COUNT_W=16 counter width.
- One natural sub-module: sat_counter (width parameter, increment, clear), instantiated twice for drop_count and sent_count.

Test Plan:
- Single upstream event 64'h0000_0000_DEAD_BEEF (bit 62=0); upstream enables=4'b0011, tx_busy=0 -> fifo_rd at cycle 1, ld_tx_data at cycle 4, fifo_data held for 5 cycles, sent_count=1.
- Downstream event 64'h4000_0000_0000_0001; downstream enables=4'b1000, tx_busy=4'b1000 for 10 cycles -> ld_tx_data exactly one cycle after tx_busy[3] falls, tx_timeout_flag=0.
- Empty mask: enables all 0, one event queued -> no ld_tx_data, drop_count=1, state returns to IDLE within 4 cycles.
- Timeout: tx_busy[0] held high, upstream enables=4'b0001 -> forced ld_tx_data after 63 wait cycles, tx_timeout_flag=1; clear_flags pulse -> flag=0 and counts=0.
- Burst of 3 events, targets idle -> ld_tx_data pulses spaced 9 cycles apart; sched_enable dropped after the second pop -> the second event still loads and the third stays in the FIFO.
- Reset asserted during WAIT_IDLE -> next cycle all outputs are 0; after release, the next queued event follows the normal 4-cycle latency.
